// File: rtl/ps2_key_decoder_if.sv
// PS/2 line and key-event bundle for ps2_key_decoder.
// master: keyboard/host side; slave: the decoder. dbg_state mirrors the receive FSM.
`timescale 1ns/1ps
interface ps2_key_decoder_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [10:0] ps2_key;
  logic        frame_err;
  logic [1:0]  dbg_state;

  modport master (output ps2_clk, ps2_data, input ps2_key, frame_err, dbg_state);
  modport slave  (input ps2_clk, ps2_data, output ps2_key, frame_err, dbg_state);
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes the raw lines, deframes 11-bit frames and
// reports make/break events with E0 extension; PS2_TIMEOUT_EN adds an inactivity watchdog.
`timescale 1ns/1ps
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input logic              clk_sys,
  input logic              reset_n,
  ps2_key_decoder_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic        clk_s1_q, clk_s2_q, clk_h_q;
  logic        dat_s1_q, dat_s2_q, dat_h_q;
  logic [1:0]  state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        parity_q, parity_d;
  logic        ext_q, ext_d;
  logic        rel_q, rel_d;
  logic [2:0]  skip_q, skip_d;
  logic [10:0] key_q, key_d;
  logic        err_q, err_d;
  logic        fall;
  logic        frame_ok;

`ifdef PS2_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_q, to_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  assign fall     = clk_h_q & ~clk_s2_q;
  // Odd parity over data+parity, and a high stop bit, sampled on the stop edge.
  assign frame_ok = (^{shift_q, parity_q}) & dat_s2_q;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    ext_d     = ext_q;
    rel_d     = rel_q;
    skip_d    = skip_q;
    key_d     = key_q;
    err_d     = 1'b0;
    if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          shift_d   = {dat_s2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          parity_d = dat_s2_q;
          state_d  = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (frame_ok) begin
            // Pause-sequence suppression takes precedence over prefix decoding.
            if (skip_q != 3'd0) begin
              skip_d = skip_q - 3'd1;
            end else begin
              case (shift_q)
                8'hE0: ext_d = 1'b1;
                8'hF0: rel_d = 1'b1;
                8'hE1: skip_d = 3'd7;
                8'h00, 8'hFF: begin
                  ext_d = 1'b0;
                  rel_d = 1'b0;
                end
                default: begin
                  key_d = {~key_q[10], ~rel_q, ext_q, shift_q};
                  ext_d = 1'b0;
                  rel_d = 1'b0;
                end
              endcase
            end
          end else begin
            err_d  = 1'b1;
            ext_d  = 1'b0;
            rel_d  = 1'b0;
            skip_d = 3'd0;
          end
        end
      endcase
    end
`ifdef PS2_TIMEOUT_EN
    to_d = to_q;
    if (state_q == S_IDLE || fall) begin
      to_d = '0;
    end else if (to_q >= TO_W'(TIMEOUT_CYCLES)) begin
      // No edge this cycle, so this abort cannot coincide with a key update.
      to_d    = '0;
      state_d = S_IDLE;
      ext_d   = 1'b0;
      rel_d   = 1'b0;
      skip_d  = 3'd0;
      err_d   = 1'b1;
    end else begin
      to_d = to_q + TO_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q  <= 1'b1;
      clk_s2_q  <= 1'b1;
      clk_h_q   <= 1'b1;
      dat_s1_q  <= 1'b1;
      dat_s2_q  <= 1'b1;
      dat_h_q   <= 1'b1;
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'd0;
      parity_q  <= 1'b0;
      ext_q     <= 1'b0;
      rel_q     <= 1'b0;
      skip_q    <= 3'd0;
      key_q     <= 11'd0;
      err_q     <= 1'b0;
`ifdef PS2_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      clk_s1_q  <= bus.ps2_clk;
      clk_s2_q  <= clk_s1_q;
      clk_h_q   <= clk_s2_q;
      dat_s1_q  <= bus.ps2_data;
      dat_s2_q  <= dat_s1_q;
      dat_h_q   <= dat_s2_q;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      ext_q     <= ext_d;
      rel_q     <= rel_d;
      skip_q    <= skip_d;
      key_q     <= key_d;
      err_q     <= err_d;
`ifdef PS2_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  // The data history flop is kept for symmetry with the clock path; only its
  // synchronized value feeds the FSM.
  logic unused_dat_h;
  assign unused_dat_h = dat_h_q;

  assign bus.ps2_key   = key_q;
  assign bus.frame_err = err_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Self-checking bench for ps2_key_decoder: directed scenarios plus randomized
// frames checked against a byte-level reference model of the key protocol.
`timescale 1ns/1ps
module tb_ps2_key_decoder;
  localparam int HALF = 6;

  logic clk_sys = 1'b0;
  logic reset_n = 1'b0;
  ps2_key_decoder_if bus();

  ps2_key_decoder #(.TIMEOUT_CYCLES(100)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  int vectors = 0;
  int miscompares = 0;

  int cyc = 0;
  int fall_cyc = 0;
  int last_upd_cyc = 0;
  int n_upd = 0, n_err = 0, n_wide = 0, n_collide = 0;
  logic [10:0] key_prev = '0;
  logic        err_prev = 1'b0;

  // reference model state
  logic [10:0] m_key;
  logic        m_ext, m_rel;
  int          m_skip;
  int          m_upd = 0, m_err = 0;
  logic [10:0] exp_q[$];

  always @(posedge clk_sys) cyc <= cyc + 1;

  always @(negedge clk_sys) begin
    if (!reset_n) begin
      key_prev = bus.ps2_key;
      err_prev = 1'b0;
    end else begin
      if (bus.ps2_key !== key_prev) begin
        n_upd++;
        last_upd_cyc = cyc;
        if (bus.frame_err) n_collide++;
      end
      if (bus.frame_err === 1'b1) begin
        n_err++;
        if (err_prev) n_wide++;
      end
      err_prev = bus.frame_err;
      key_prev = bus.ps2_key;
    end
  end

  function automatic void model_reset();
    m_key = '0; m_ext = 1'b0; m_rel = 1'b0; m_skip = 0;
  endfunction

  function automatic void model_frame(input logic [7:0] b, input bit ok);
    if (!ok) begin
      m_ext = 1'b0; m_rel = 1'b0; m_skip = 0; m_err++;
    end else if (m_skip > 0) begin
      m_skip--;
    end else if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'h00 || b == 8'hFF) begin
      m_ext = 1'b0; m_rel = 1'b0;
    end else begin
      m_key = {~m_key[10], ~m_rel, m_ext, b};
      exp_q.push_back(m_key);
      m_ext = 1'b0; m_rel = 1'b0; m_upd++;
    end
  endfunction

  task automatic send_bit(input bit v);
    @(negedge clk_sys);
    bus.ps2_data = v;
    repeat (HALF) @(negedge clk_sys);
    bus.ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(negedge clk_sys);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int gap);
    logic par;
    par = ~(^b) ^ bad_par;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(par);
    send_bit(~bad_stop);
    model_frame(b, !(bad_par || bad_stop));
    repeat (gap) @(negedge clk_sys);
  endtask

  task automatic do_reset();
    @(negedge clk_sys);
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    reset_n = 1'b0;
    model_reset();
    exp_q.delete();
    #1;
    vectors++;
    if (bus.ps2_key !== 11'h000 || bus.frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_immediate key=%h err=%b want key=000 err=0", bus.ps2_key, bus.frame_err);
    end
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (bus.dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_state state=%0d want 0 (idle)", bus.dbg_state);
    end
  endtask

  task automatic test_basic();
    int u0, e0;
    u0 = n_upd; e0 = n_err;
    send_frame(8'h1C, 0, 0, 4);
    vectors += 4;
    if (bus.ps2_key !== 11'h61C) begin
      miscompares++; $display("FAIL basic_key got=%h want=61C", bus.ps2_key);
    end
    if (last_upd_cyc - fall_cyc !== 3) begin
      miscompares++;
      $display("FAIL basic_latency got=%0d want=3 cycles after stop edge", last_upd_cyc - fall_cyc);
    end
    if (n_err !== e0) begin
      miscompares++; $display("FAIL basic_err got=%0d want=%0d", n_err, e0);
    end
    if (exp_q.size() == 0 || exp_q.pop_front() !== bus.ps2_key) begin
      miscompares++; $display("FAIL basic_scoreboard got=%h", bus.ps2_key);
    end
    u0 = n_upd;
    send_frame(8'hF0, 0, 0, 4);
    vectors++;
    if (n_upd !== u0) begin
      miscompares++; $display("FAIL break_prefix_no_update updates=%0d want=%0d", n_upd, u0);
    end
    send_frame(8'h1C, 0, 0, 4);
    vectors += 2;
    if (bus.ps2_key !== 11'h01C) begin
      miscompares++; $display("FAIL break_key got=%h want=01C", bus.ps2_key);
    end
    if (n_upd !== u0 + 1) begin
      miscompares++; $display("FAIL break_single_update got=%0d want=%0d", n_upd, u0 + 1);
    end
  endtask

  task automatic test_extended();
    logic b10;
    b10 = bus.ps2_key[10];
    send_frame(8'hE0, 0, 0, 2);
    send_frame(8'h6B, 0, 0, 2);
    vectors += 2;
    if (bus.ps2_key[9:0] !== 10'h36B) begin
      miscompares++; $display("FAIL ext_make got=%h want=36B", bus.ps2_key[9:0]);
    end
    if (bus.ps2_key[10] === b10) begin
      miscompares++; $display("FAIL ext_toggle got=%b want=%b", bus.ps2_key[10], ~b10);
    end
    send_frame(8'hE0, 0, 0, 0);
    send_frame(8'hF0, 0, 0, 0);
    send_frame(8'h6B, 0, 0, 2);
    vectors++;
    if (bus.ps2_key[9:0] !== 10'h16B) begin
      miscompares++; $display("FAIL ext_break got=%h want=16B", bus.ps2_key[9:0]);
    end
  endtask

  task automatic test_frame_error();
    logic [10:0] k0;
    int e0;
    k0 = bus.ps2_key; e0 = n_err;
    send_frame(8'h1C, 1, 0, 4);
    vectors += 3;
    if (n_err !== e0 + 1) begin
      miscompares++; $display("FAIL parity_err_count got=%0d want=%0d", n_err, e0 + 1);
    end
    if (n_wide !== 0) begin
      miscompares++; $display("FAIL err_pulse_width wide=%0d want=0", n_wide);
    end
    if (bus.ps2_key !== k0) begin
      miscompares++; $display("FAIL parity_key_hold got=%h want=%h", bus.ps2_key, k0);
    end
    send_frame(8'h1C, 0, 0, 4);
    vectors++;
    if (bus.ps2_key[10] === k0[10] || bus.ps2_key !== m_key) begin
      miscompares++; $display("FAIL after_err_key got=%h want=%h", bus.ps2_key, m_key);
    end
    // bad stop bit also discards, and clears a pending break prefix
    send_frame(8'hF0, 0, 0, 2);
    send_frame(8'h33, 0, 1, 2);
    send_frame(8'h33, 0, 0, 2);
    vectors += 2;
    if (n_err !== e0 + 2) begin
      miscompares++; $display("FAIL stop_err_count got=%0d want=%0d", n_err, e0 + 2);
    end
    if (bus.ps2_key !== m_key) begin
      miscompares++; $display("FAIL stop_err_key got=%h want=%h", bus.ps2_key, m_key);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [8];
    int u0;
    seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
    u0 = n_upd;
    for (int i = 0; i < 8; i++) send_frame(seq[i], 0, 0, 1);
    vectors++;
    if (n_upd !== u0) begin
      miscompares++; $display("FAIL pause_suppressed updates=%0d want=%0d", n_upd, u0);
    end
    send_frame(8'h29, 0, 0, 2);
    vectors++;
    if (bus.ps2_key[9:0] !== 10'h229) begin
      miscompares++; $display("FAIL pause_then_key got=%h want=229", bus.ps2_key[9:0]);
    end
  endtask

  task automatic test_back_to_back();
    int u0;
    u0 = n_upd;
    send_frame(8'h15, 0, 0, 0);
    send_frame(8'h24, 0, 0, 0);
    send_frame(8'h2D, 0, 0, 2);
    vectors += 2;
    if (n_upd !== u0 + 3) begin
      miscompares++; $display("FAIL b2b_updates got=%0d want=%0d", n_upd, u0 + 3);
    end
    if (bus.ps2_key !== m_key) begin
      miscompares++; $display("FAIL b2b_key got=%h want=%h", bus.ps2_key, m_key);
    end
  endtask

`ifdef PS2_TIMEOUT_EN
  task automatic test_timeout();
    int e0, waited;
    e0 = n_err;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    waited = 0;
    while (n_err == e0 && waited < 400) begin
      @(negedge clk_sys);
      waited++;
    end
    m_ext = 1'b0; m_rel = 1'b0; m_skip = 0; m_err++;
    repeat (2) @(negedge clk_sys);
    vectors += 2;
    if (n_err !== e0 + 1) begin
      miscompares++; $display("FAIL timeout_err got=%0d want=%0d", n_err, e0 + 1);
    end
    if (bus.dbg_state !== 2'd0) begin
      miscompares++; $display("FAIL timeout_idle state=%0d want 0", bus.dbg_state);
    end
    send_frame(8'h1C, 0, 0, 2);
    vectors++;
    if (bus.ps2_key !== m_key) begin
      miscompares++; $display("FAIL timeout_recover got=%h want=%h", bus.ps2_key, m_key);
    end
  endtask
`else
  task automatic test_stall();
    int e0;
    e0 = n_err;
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    repeat (300) @(negedge clk_sys);
    vectors += 2;
    if (n_err !== e0) begin
      miscompares++; $display("FAIL stall_no_err got=%0d want=%0d", n_err, e0);
    end
    if (bus.dbg_state === 2'd0) begin
      miscompares++; $display("FAIL stall_persist state=%0d want not idle", bus.dbg_state);
    end
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1);
    model_frame(8'h1C, 1);
    repeat (2) @(negedge clk_sys);
    vectors++;
    if (bus.ps2_key !== m_key) begin
      miscompares++; $display("FAIL stall_resume got=%h want=%h", bus.ps2_key, m_key);
    end
  endtask
`endif

  task automatic test_reset_mid_frame();
    int e0;
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    e0 = n_err;
    do_reset();
    vectors += 2;
    if (n_err !== e0 || bus.frame_err !== 1'b0) begin
      miscompares++; $display("FAIL midreset_err got=%0d want=%0d", n_err, e0);
    end
    if (bus.ps2_key !== 11'h000 || bus.dbg_state !== 2'd0) begin
      miscompares++;
      $display("FAIL midreset_state key=%h state=%0d want 000/0", bus.ps2_key, bus.dbg_state);
    end
    send_frame(8'h1C, 0, 0, 2);
    vectors++;
    if (bus.ps2_key !== 11'h61C) begin
      miscompares++; $display("FAIL midreset_recover got=%h want=61C", bus.ps2_key);
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r, f;
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 19);
      case (r)
        0, 1:    b = 8'hE0;
        2, 3:    b = 8'hF0;
        4:       b = 8'hE1;
        5:       b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
        default: b = 8'($urandom_range(0, 255));
      endcase
      f = $urandom_range(0, 11);
      send_frame(b, f == 0, f == 1, $urandom_range(0, 3));
      repeat (1) @(negedge clk_sys);
      vectors += 3;
      if (bus.ps2_key !== m_key) begin
        miscompares++; $display("FAIL rand_key[%0d] byte=%h got=%h want=%h", n, b, bus.ps2_key, m_key);
      end
      if (n_upd !== m_upd) begin
        miscompares++; $display("FAIL rand_updates[%0d] got=%0d want=%0d", n, n_upd, m_upd);
      end
      if (n_err !== m_err) begin
        miscompares++; $display("FAIL rand_errs[%0d] got=%0d want=%0d", n, n_err, m_err);
      end
    end
  endtask

  task automatic test_invariants();
    vectors += 2;
    if (n_collide !== 0) begin
      miscompares++; $display("FAIL err_key_same_cycle got=%0d want=0", n_collide);
    end
    if (n_wide !== 0) begin
      miscompares++; $display("FAIL err_pulse_width got=%0d want=0", n_wide);
    end
  endtask

  initial begin
    bus.ps2_clk = 1'b1;
    bus.ps2_data = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_extended();
    test_frame_error();
    test_pause();
    test_back_to_back();
    m_upd = n_upd; m_err = n_err;
`ifdef PS2_TIMEOUT_EN
    test_timeout();
`else
    test_stall();
`endif
    test_reset_mid_frame();
    m_upd = n_upd; m_err = n_err;
    test_random();
    test_invariants();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 50000, clk_sys cycles of PS/2 clock inactivity before a partial frame is aborted.
REQ-002 clk_sys  input  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk_sys.
REQ-005 ps2_data  input  1  raw PS/2 data line, asynchronous to clk_sys.
REQ-006 ps2_key  output  11  key event word:
  - [10] toggles once per event.
  - [9] is 1 on press, 0 on release.
  - [8] is the E0-extended flag.
  - [7:0] is the scan code.
REQ-007 frame_err  output  1  one-cycle pulse on a discarded frame.

Function
REQ-008 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer followed by one history flop.
REQ-009 A falling edge SHALL be detected when the history flop is 1 and the synchronized value is 0.
REQ-010 Receive FSM states: IDLE, DATA, PARITY, STOP. All sampling occurs only on a detected falling edge, using the synchronized data.
REQ-011 IDLE: on a falling edge with data 0 (start bit), go to DATA with the bit counter at 0. With data 1, stay in IDLE and take no other action.
REQ-012 DATA: shift data in LSB first. After the 8th bit, go to PARITY.
REQ-013 PARITY: store the bit and go to STOP. The frame is valid if data bits plus parity bit have odd parity.
REQ-014 STOP: return to IDLE on the falling edge. The frame is accepted only if parity is good and the stop bit is 1. Otherwise pulse frame_err on the following cycle and clear the ext, rel and skip state.
REQ-015 Accepted byte 0xE0: set the ext flag; no output.
REQ-016 Accepted byte 0xF0: set the rel flag; no output.
REQ-017 Accepted byte 0xE1: load skip counter = 7; no output. While skip > 0, each accepted byte decrements skip and is discarded (Pause sequence suppressed).
REQ-018 Accepted byte 0x00 or 0xFF (keyboard overrun): discard and clear ext/rel.
REQ-019 Any other accepted byte: in the cycle after the stop-bit edge, ps2_key SHALL become {~ps2_key[10], ~rel, ext, byte}, and ext/rel SHALL clear in the same cycle.
REQ-020 ps2_key SHALL hold its value between events. Bit 10 SHALL change exactly once per reported event.
REQ-021 Back-to-back frames with no idle gap SHALL be decoded without loss.
REQ-022 frame_err and a ps2_key update SHALL never occur in the same cycle.

Reset
REQ-023 Asserting reset_n low SHALL immediately force:
  - ps2_key = 0, frame_err = 0
  - FSM = IDLE
  - bit counter, ext, rel, skip and timeout counter = 0
  - synchronizer and history flops = 1
REQ-024 Reset asserted mid-frame SHALL discard the partial frame with no frame_err. The next full frame after release SHALL decode normally.

Configuration
REQ-025 Macro PS2_TIMEOUT_EN, when defined, adds the inactivity watchdog:
  - The counter clears on every detected falling edge and in IDLE.
  - Outside IDLE it increments each cycle.
  - When it reaches TIMEOUT_CYCLES, the FSM returns to IDLE, ext/rel/skip clear, and frame_err pulses one cycle.
REQ-026 With PS2_TIMEOUT_EN undefined:
  - No counter logic exists.
  - A stalled partial frame persists until further edges arrive or reset.
  - TIMEOUT_CYCLES is unused.

Verification
REQ-027 Frame 0x1C (parity 0, stop 1) from reset -> ps2_key = 11'h61C one cycle after the stop edge; no frame_err.
REQ-028 Frames F0, 1C following REQ-027 -> single update to 11'h01C; no update after F0 alone.
REQ-029 Frames E0, 6B -> ps2_key[9:0] = 10'h36B, bit 10 toggled. A following E0, F0, 6B -> ps2_key[9:0] = 10'h16B.
REQ-030 Frame 0x1C with parity bit 1 -> frame_err high exactly one cycle, ps2_key unchanged. A following valid 0x1C -> bit 10 toggles.
REQ-031 Pause sequence E1 14 77 E1 F0 14 F0 77, then 0x29 -> no ps2_key change for the 8 bytes, then ps2_key[9:0] = 10'h229.
REQ-032 With PS2_TIMEOUT_EN and TIMEOUT_CYCLES = 100: start bit plus 3 data bits, then 100 idle cycles -> frame_err pulse, FSM in IDLE. A following valid 0x1C decodes correctly.
REQ-033 Reset pulse after 5 bits of a frame -> outputs at reset values, no frame_err. A following valid frame 0x1C -> ps2_key = 11'h61C.
